param_sync_fifo: RTL and testbench
==================================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 64, number of entries (>=2; power of two not required).
REQ-003 SHALL have parameter PORTS, default 2, storage port model (1 = single-port, 2 = dual-port).
REQ-004 SHALL have parameter AE_LEVEL, default 1, almost-empty threshold (0..DEPTH-1).
REQ-005 SHALL have parameter AF_LEVEL, default 1, almost-full threshold (0..DEPTH-1).
REQ-006 SHALL define derived widths AW = clog2(DEPTH) and CW = clog2(DEPTH+1).
REQ-007 SHALL have one clock and an asynchronous, active-high reset, as the following two port lines state.
REQ-008 clk  input  1  sole clock; all state updates on the rising edge.
REQ-009 reset  input  1  asynchronous, active-high reset.
REQ-010 fifo_wr  input  1  push request.
REQ-011 fifo_rd  input  1  pop request.
REQ-012 fifo_din  input  WIDTH  push data.
REQ-013 err_clr  input  1  clears sticky error bits.
REQ-014 fifo_mt  output  1  empty flag.
REQ-015 fifo_amt  output  1  almost-empty flag.
REQ-016 fifo_afull  output  1  almost-full flag.
REQ-017 fifo_full  output  1  full flag.
REQ-018 fifo_cnt  output  CW  current occupancy.
REQ-019 fifo_err  output  1  OR of fifo_err_code.
REQ-020 fifo_err_code  output  3  sticky errors: [0] overflow, [1] underflow, [2] single-port read/write conflict.
REQ-021 fifo_rd_vld  output  1  fifo_dout is valid this cycle.
REQ-022 fifo_dout  output  WIDTH  pop data (registered).

Function
REQ-023 SHALL use a flop-array store plus write pointer, read pointer and occupancy counter; both pointers wrap from DEPTH-1 to 0.
REQ-024 SHALL accept a push when fifo_wr=1 and either fifo_cnt<DEPTH, or PORTS=2 with a pop accepted in the same cycle.
REQ-025 SHALL accept a pop when fifo_rd=1, fifo_cnt>0 and the cycle is not a PORTS=1 conflict; there is no fall-through when empty.
REQ-026 PORTS=1 with fifo_wr=1 and fifo_rd=1 in the same cycle: the write SHALL proceed per REQ-024, the read SHALL be ignored, and err_code[2] SHALL be set.
REQ-027 On an accepted pop in cycle N, fifo_rd_vld SHALL be 1 and fifo_dout SHALL hold the head entry in cycle N+1 (read latency 1).
REQ-028 fifo_rd_vld SHALL be 0 in cycles not following an accepted pop; fifo_dout SHALL hold its last value.
REQ-029 fifo_cnt SHALL be +1 on push only, -1 on pop only, and unchanged on push+pop or on neither.
REQ-030 A push with fifo_wr=1 while full and no accepted pop SHALL be dropped, with storage and pointers unchanged, and err_code[0] set.
REQ-031 A pop with fifo_rd=1 while empty SHALL be ignored, with err_code[1] set and no fifo_rd_vld.
REQ-032 Error bits SHALL be sticky; err_clr SHALL clear them at the next edge; a new error in the same cycle as err_clr SHALL win.
REQ-033 Flags SHALL decode from the registered count:
- fifo_mt = (cnt==0)
- fifo_amt = (cnt<=AE_LEVEL)
- fifo_afull = (cnt>=DEPTH-AF_LEVEL)
- fifo_full = (cnt==DEPTH)
REQ-034 Illegal parameters SHALL raise an elaboration-time fatal error: WIDTH<1, DEPTH<2, PORTS not 1 or 2, AE_LEVEL>=DEPTH, or AF_LEVEL>=DEPTH.

Reset
REQ-035 Asserting reset SHALL immediately clear pointers, fifo_cnt, fifo_err_code, fifo_rd_vld and fifo_dout to 0; the storage array is not reset.
REQ-036 During and after reset: fifo_mt=1, fifo_amt=1, fifo_full=0, fifo_afull=0, fifo_err=0.
REQ-037 Reset asserted mid-operation SHALL discard all contents; the first pop after deassertion SHALL report underflow.

Verification
REQ-038 Defaults: push 0x0000..0x003F over 64 cycles -> fifo_full=1, fifo_cnt=64, fifo_afull first seen at cnt=63; 64 pops -> data returned in order one cycle after each pop, fifo_mt=1.
REQ-039 Full with PORTS=2: push 0xAAAA together with a pop -> both accepted, cnt stays 64, no error; 0xAAAA emerges as the 64th subsequent pop.
REQ-040 Full, push without pop -> data dropped, err_code=3'b001; err_clr pulse -> fifo_err=0 next cycle.
REQ-041 PORTS=1, cnt=5, fifo_wr and fifo_rd together -> cnt=6, no fifo_rd_vld, err_code[2]=1.
REQ-042 DEPTH=5: 12 push/pop pairs spanning pointer wrap -> data in order, cnt bounded 0..5; pop when empty -> err_code[1]=1, fifo_rd_vld=0.
REQ-043 Reset asserted between clock edges at cnt=10 -> outputs cleared without waiting for an edge; fifo_mt=1, fifo_cnt=0.

Source files
------------

// File: rtl/param_sync_fifo_if.sv
// Handshake and status bundle for param_sync_fifo.
// The master side pushes and pops; the slave side is the FIFO itself.
interface param_sync_fifo_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             fifo_wr;
  logic             fifo_rd;
  logic [WIDTH-1:0] fifo_din;
  logic             err_clr;
  logic             fifo_mt;
  logic             fifo_amt;
  logic             fifo_afull;
  logic             fifo_full;
  logic [CW-1:0]    fifo_cnt;
  logic             fifo_err;
  logic [2:0]       fifo_err_code;
  logic             fifo_rd_vld;
  logic [WIDTH-1:0] fifo_dout;

  modport master (
    output fifo_wr, fifo_rd, fifo_din, err_clr,
    input  fifo_mt, fifo_amt, fifo_afull, fifo_full, fifo_cnt,
           fifo_err, fifo_err_code, fifo_rd_vld, fifo_dout
  );

  modport slave (
    input  fifo_wr, fifo_rd, fifo_din, err_clr,
    output fifo_mt, fifo_amt, fifo_afull, fifo_full, fifo_cnt,
           fifo_err, fifo_err_code, fifo_rd_vld, fifo_dout
  );
endinterface

// File: rtl/param_sync_fifo.sv
// Single-clock flop-array FIFO with occupancy flags, sticky error reporting
// and a registered one-cycle read path; single- or dual-port storage model.
module param_sync_fifo #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 64,
  parameter int PORTS    = 2,
  parameter int AE_LEVEL = 1,
  parameter int AF_LEVEL = 1
) (
  input logic               clk,
  input logic               reset,
  param_sync_fifo_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Parameter legality is checked while elaborating, before any simulation.
  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "param_sync_fifo: WIDTH must be >= 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $fatal(1, "param_sync_fifo: DEPTH must be >= 2");
  end
  if (PORTS != 1 && PORTS != 2) begin : g_bad_ports
    $fatal(1, "param_sync_fifo: PORTS must be 1 or 2");
  end
  if (AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : g_bad_ae
    $fatal(1, "param_sync_fifo: AE_LEVEL must be in 0..DEPTH-1");
  end
  if (AF_LEVEL < 0 || AF_LEVEL >= DEPTH) begin : g_bad_af
    $fatal(1, "param_sync_fifo: AF_LEVEL must be in 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [2:0]       err_code;
  logic             rd_vld;
  logic [WIDTH-1:0] dout;

  logic             conflict_c;
  logic             empty_c;
  logic             full_c;
  logic             pop_ok_c;
  logic             push_ok_c;
  logic [2:0]       err_set_c;
  logic [2:0]       err_next_c;

  // Accept decisions: a single-port conflict suppresses the read only.
  always_comb begin
    conflict_c = 1'b0;
    empty_c    = (cnt == '0);
    full_c     = (cnt == CW'(DEPTH));
    if (PORTS == 1) begin
      conflict_c = bus.fifo_wr && bus.fifo_rd;
    end
    pop_ok_c  = bus.fifo_rd && !empty_c && !conflict_c;
    push_ok_c = bus.fifo_wr && (!full_c || ((PORTS == 2) && pop_ok_c));
  end

  // New errors override a same-cycle clear.
  always_comb begin
    err_set_c    = 3'b000;
    err_set_c[0] = bus.fifo_wr && !push_ok_c;
    err_set_c[1] = bus.fifo_rd && empty_c;
    err_set_c[2] = conflict_c;
    err_next_c   = (bus.err_clr ? 3'b000 : err_code) | err_set_c;
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem[wr_ptr] <= bus.fifo_din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      err_code <= 3'b000;
      rd_vld   <= 1'b0;
      dout     <= '0;
    end else begin
      err_code <= err_next_c;
      rd_vld   <= pop_ok_c;
      if (push_ok_c) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      end
      if (pop_ok_c) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
        dout   <= mem[rd_ptr];
      end
      if (push_ok_c && !pop_ok_c) begin
        cnt <= cnt + CW'(1);
      end else if (pop_ok_c && !push_ok_c) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Status flags decode directly from the registered occupancy.
  assign bus.fifo_mt       = (cnt == '0);
  assign bus.fifo_amt      = (cnt <= CW'(AE_LEVEL));
  assign bus.fifo_afull    = (cnt >= CW'(DEPTH - AF_LEVEL));
  assign bus.fifo_full     = (cnt == CW'(DEPTH));
  assign bus.fifo_cnt      = cnt;
  assign bus.fifo_err      = |err_code;
  assign bus.fifo_err_code = err_code;
  assign bus.fifo_rd_vld   = rd_vld;
  assign bus.fifo_dout     = dout;
endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench for param_sync_fifo: default config, single-port depth-8
// and dual-port depth-5 instances driven with directed vectors.
module tb_param_sync_fifo;
  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] q2[$];

  always #5 clk = ~clk;

  param_sync_fifo_if #(.WIDTH(16), .DEPTH(64)) i0 ();
  param_sync_fifo_if #(.WIDTH(16), .DEPTH(8))  i1 ();
  param_sync_fifo_if #(.WIDTH(16), .DEPTH(5))  i2 ();

  param_sync_fifo #(.WIDTH(16), .DEPTH(64), .PORTS(2)) d0 (.clk(clk), .reset(reset), .bus(i0));
  param_sync_fifo #(.WIDTH(16), .DEPTH(8),  .PORTS(1)) d1 (.clk(clk), .reset(reset), .bus(i1));
  param_sync_fifo #(.WIDTH(16), .DEPTH(5),  .PORTS(2)) d2 (.clk(clk), .reset(reset), .bus(i2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every valid output must match the oldest expected pop.
  always @(negedge clk) begin
    if (i0.fifo_rd_vld === 1'b1) begin
      if (q0.size() == 0) chk("d0_extra_vld_qsize", 32'(q0.size()), 32'd1);
      else chk("d0_dout", 32'(i0.fifo_dout), 32'(q0.pop_front()));
    end
    if (i1.fifo_rd_vld === 1'b1) begin
      if (q1.size() == 0) chk("d1_extra_vld_qsize", 32'(q1.size()), 32'd1);
      else chk("d1_dout", 32'(i1.fifo_dout), 32'(q1.pop_front()));
    end
    if (i2.fifo_rd_vld === 1'b1) begin
      if (q2.size() == 0) chk("d2_extra_vld_qsize", 32'(q2.size()), 32'd1);
      else chk("d2_dout", 32'(i2.fifo_dout), 32'(q2.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    {i0.fifo_wr, i0.fifo_rd, i0.err_clr} = 3'b000; i0.fifo_din = '0;
    {i1.fifo_wr, i1.fifo_rd, i1.err_clr} = 3'b000; i1.fifo_din = '0;
    {i2.fifo_wr, i2.fifo_rd, i2.err_clr} = 3'b000; i2.fifo_din = '0;
    repeat (2) cyc();

    // Reset state
    chk("rst_mt",    32'(i0.fifo_mt), 32'd1);
    chk("rst_amt",   32'(i0.fifo_amt), 32'd1);
    chk("rst_full",  32'(i0.fifo_full), 32'd0);
    chk("rst_afull", 32'(i0.fifo_afull), 32'd0);
    chk("rst_err",   32'(i0.fifo_err), 32'd0);
    chk("rst_cnt",   32'(i0.fifo_cnt), 32'd0);
    chk("rst_vld",   32'(i0.fifo_rd_vld), 32'd0);
    chk("rst_dout",  32'(i0.fifo_dout), 32'd0);
    reset = 1'b0;

    // Default config: fill 0x0000..0x003F
    for (int i = 0; i < 64; i++) begin
      i0.fifo_wr = 1'b1; i0.fifo_din = 16'(i);
      cyc();
      chk("fill_cnt",   32'(i0.fifo_cnt), 32'(i + 1));
      chk("fill_afull", 32'(i0.fifo_afull), 32'(i + 1 >= 63));
      chk("fill_amt",   32'(i0.fifo_amt), 32'(i + 1 <= 1));
      chk("fill_mt",    32'(i0.fifo_mt), 32'd0);
    end
    i0.fifo_wr = 1'b0;
    chk("fill_full", 32'(i0.fifo_full), 32'd1);

    // Full, push with pop on a dual-port store
    i0.fifo_wr = 1'b1; i0.fifo_rd = 1'b1; i0.fifo_din = 16'hAAAA;
    q0.push_back(16'h0000);
    cyc();
    i0.fifo_wr = 1'b0; i0.fifo_rd = 1'b0;
    chk("pp_full_cnt", 32'(i0.fifo_cnt), 32'd64);
    chk("pp_full_err", 32'(i0.fifo_err_code), 32'd0);

    // Full, push without pop: dropped with overflow
    i0.fifo_wr = 1'b1; i0.fifo_din = 16'hBBBB;
    cyc();
    i0.fifo_wr = 1'b0;
    chk("ovf_code", 32'(i0.fifo_err_code), 32'b001);
    chk("ovf_err",  32'(i0.fifo_err), 32'd1);
    chk("ovf_cnt",  32'(i0.fifo_cnt), 32'd64);
    i0.err_clr = 1'b1;
    cyc();
    i0.err_clr = 1'b0;
    chk("clr_err",  32'(i0.fifo_err), 32'd0);
    chk("clr_code", 32'(i0.fifo_err_code), 32'd0);

    // Drain: 0x0001..0x003F then 0xAAAA
    for (int i = 0; i < 64; i++) begin
      i0.fifo_rd = 1'b1;
      q0.push_back(i < 63 ? 16'(i + 1) : 16'hAAAA);
      cyc();
      chk("drain_cnt", 32'(i0.fifo_cnt), 32'(63 - i));
    end
    i0.fifo_rd = 1'b0;
    cyc();
    chk("drain_mt",  32'(i0.fifo_mt), 32'd1);
    chk("drain_vld", 32'(i0.fifo_rd_vld), 32'd0);
    chk("drain_err", 32'(i0.fifo_err), 32'd0);

    // Single-port depth 8: conflict at cnt=5
    for (int i = 0; i < 5; i++) begin
      i1.fifo_wr = 1'b1; i1.fifo_din = 16'(16'h10 + i);
      cyc();
    end
    chk("sp_cnt5", 32'(i1.fifo_cnt), 32'd5);
    i1.fifo_rd = 1'b1; i1.fifo_din = 16'h15;
    cyc();
    i1.fifo_wr = 1'b0; i1.fifo_rd = 1'b0;
    chk("sp_conf_cnt",  32'(i1.fifo_cnt), 32'd6);
    chk("sp_conf_vld",  32'(i1.fifo_rd_vld), 32'd0);
    chk("sp_conf_code", 32'(i1.fifo_err_code), 32'b100);
    for (int i = 0; i < 6; i++) begin
      i1.fifo_rd = 1'b1;
      q1.push_back(16'(16'h10 + i));
      cyc();
    end
    i1.fifo_rd = 1'b0;
    chk("sp_drain_mt", 32'(i1.fifo_mt), 32'd1);

    // Depth 5: fill, 12 push/pop pairs across pointer wrap, drain
    for (int i = 0; i < 5; i++) begin
      i2.fifo_wr = 1'b1; i2.fifo_din = 16'(16'h100 + i);
      cyc();
    end
    i2.fifo_wr = 1'b0;
    chk("d5_full",  32'(i2.fifo_full), 32'd1);
    chk("d5_afull", 32'(i2.fifo_afull), 32'd1);
    chk("d5_cnt",   32'(i2.fifo_cnt), 32'd5);
    for (int k = 0; k < 12; k++) begin
      i2.fifo_wr = 1'b1; i2.fifo_rd = 1'b1; i2.fifo_din = 16'(16'h105 + k);
      q2.push_back(16'(16'h100 + k));
      cyc();
      chk("d5_pair_cnt", 32'(i2.fifo_cnt), 32'd5);
      chk("d5_pair_err", 32'(i2.fifo_err), 32'd0);
    end
    i2.fifo_wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      i2.fifo_rd = 1'b1;
      q2.push_back(16'(16'h10C + i));
      cyc();
      chk("d5_drain_cnt", 32'(i2.fifo_cnt), 32'(4 - i));
    end
    cyc();
    chk("d5_empty_mt", 32'(i2.fifo_mt), 32'd1);
    chk("d5_udf_code", 32'(i2.fifo_err_code), 32'b010);
    chk("d5_udf_vld",  32'(i2.fifo_rd_vld), 32'd0);
    chk("d5_udf_dout", 32'(i2.fifo_dout), 32'h110);
    chk("d5_udf_cnt",  32'(i2.fifo_cnt), 32'd0);
    i2.fifo_rd = 1'b0;

    // Mid-operation asynchronous reset at cnt=10
    for (int i = 0; i < 10; i++) begin
      i0.fifo_wr = 1'b1; i0.fifo_din = 16'(16'h50 + i);
      cyc();
    end
    i0.fifo_wr = 1'b0;
    chk("pre_rst_cnt", 32'(i0.fifo_cnt), 32'd10);
    #2 reset = 1'b1;
    #1;
    chk("arst_cnt",  32'(i0.fifo_cnt), 32'd0);
    chk("arst_mt",   32'(i0.fifo_mt), 32'd1);
    chk("arst_amt",  32'(i0.fifo_amt), 32'd1);
    chk("arst_full", 32'(i0.fifo_full), 32'd0);
    chk("arst_d2err", 32'(i2.fifo_err), 32'd0);
    #2 reset = 1'b0;
    i0.fifo_rd = 1'b1;
    cyc();
    i0.fifo_rd = 1'b0;
    chk("post_rst_code", 32'(i0.fifo_err_code), 32'b010);
    chk("post_rst_vld",  32'(i0.fifo_rd_vld), 32'd0);
    cyc();
    chk("sb_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
